// File: rtl/ram_bist_if.sv
// RAM master bus between the BIST controller and a single-port RAM.
// Bus semantics: there is no valid/ready pair. M_RW is a per-cycle strobe:
// when M_RW=1 the RAM stores M_DIN at M_ADDR on the next rising CLK edge;
// when M_RW=0 the RAM drives M_DOUT combinationally from M_ADDR and the
// master samples it on that same edge.
interface ram_bist_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              M_RW;
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_DIN;
  logic [DATA_W-1:0] M_DOUT;

  modport master (output M_RW, output M_ADDR, output M_DIN, input M_DOUT);
  modport slave  (input M_RW, input M_ADDR, input M_DIN, output M_DOUT);
endinterface

// File: rtl/ram_bist_ctrl.sv
// March-style RAM self-test: write P(a) ascending, read/compare ascending,
// write ~P(a) descending, read/compare descending, then report.
// Every output is decoded from registers only; M_DOUT feeds state, never outputs.
module ram_bist_ctrl #(
  parameter int                ADDR_W  = 2,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'hA5
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  ram_bist_if.master        m,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [DATA_W-1:0] FAIL_DATA,
  output logic [ADDR_W+1:0] ERR_CNT,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_P = 3'd1,
    S_RD_P = 3'd2,
    S_WR_N = 3'd3,
    S_RD_N = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W+1:0] err_q, err_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fd_q, fd_d;
  logic [DATA_W-1:0] want;
  logic              cmp;
  logic [DATA_W-1:0] din;

  // Forward pattern: base seed plus zero-extended address, wrapping.
  function automatic logic [DATA_W-1:0] pat_p(input logic [ADDR_W-1:0] a);
    return PATTERN + DATA_W'(a);
  endfunction

  // State, address and result registers; CLR aborts immediately.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
    end
  end

  // Next-state, address sequencing and mismatch bookkeeping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fd_d    = fd_q;
    want    = '0;
    cmp     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_WR_P;
          addr_d  = '0;
          err_d   = '0;
          fa_d    = '0;
          fd_d    = '0;
        end
      end
      S_WR_P: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_RD_P;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_RD_P: begin
        want = pat_p(addr_q);
        cmp  = 1'b1;
        if (addr_q == ADDR_MAX) begin
          state_d = S_WR_N;
          addr_d  = ADDR_MAX;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_WR_N: begin
        if (addr_q == '0) begin
          state_d = S_RD_N;
          addr_d  = ADDR_MAX;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end
      S_RD_N: begin
        want = ~pat_p(addr_q);
        cmp  = 1'b1;
        if (addr_q == '0) begin
          state_d = S_DONE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
    // Count of 2N compares at most, so the ADDR_W+2 counter cannot wrap.
    if (cmp && (m.M_DOUT != want)) begin
      err_d = err_q + 1'b1;
      if (err_q == '0) begin
        fa_d = addr_q;
        fd_d = m.M_DOUT;
      end
    end
  end

  // Write data: forward pattern, inverse pattern, or idle zero.
  always_comb begin
    din = '0;
    case (state_q)
      S_WR_P:  din = pat_p(addr_q);
      S_WR_N:  din = ~pat_p(addr_q);
      default: din = '0;
    endcase
  end

  assign BUSY      = (state_q == S_WR_P) || (state_q == S_RD_P) ||
                     (state_q == S_WR_N) || (state_q == S_RD_N);
  assign m.M_RW    = (state_q == S_WR_P) || (state_q == S_WR_N);
  assign m.M_ADDR  = BUSY ? addr_q : '0;
  assign m.M_DIN   = din;
  assign DONE      = (state_q == S_DONE);
  assign PASS      = DONE && (err_q == '0);
  assign FAIL_ADDR = fa_q;
  assign FAIL_DATA = fd_q;
  assign ERR_CNT   = err_q;
  assign dbg_state = state_q;

endmodule
